adc_scan_sequencer: RTL and testbench
=====================================

// Module: adc_scan_sequencer
// PURPOSE
//  Master for the 8-channel 12-bit serial line-sensor ADC (ADC128S022-type: 16-SCLK frames, 3-bit
//  address, data delayed one frame). Round-robins conversions over the enabled channels in
//  chan_mask and drives SCLK, CS_N and DIN from one system clock. Publishes each result tagged
//  with its channel and pulses sweep_done after each full sweep. Feeds the line-follower decision
//  and PWM logic, replacing the free-running ADC clock and address logic.
// PARAMETERS
//  CLK_DIV   20  system clocks per SCLK period; even, >=4 (50 MHz -> 2.5 MHz)
//  GAP_CYC   2   clocks CS_N held high between frames; >=1
// PORTS
//  clk         in   1   system clock; all logic on posedge
//  rst_n       in   1   asynchronous active-low reset
//  scan_en     in   1   level: 1 = keep scanning
//  chan_mask   in   8   bit i = channel i enabled (line sensors: 5,6,7)
//  adc_dout    in   1   ADC serial data out
//  adc_sck     out  1   ADC serial clock; idles high
//  adc_cs_n    out  1   ADC chip select, active low
//  adc_din     out  1   ADC serial data in (address bits)
//  res_valid   out  1   1-clk strobe: res_chan/res_data valid
//  res_chan    out  3   channel of the result
//  res_data    out  12  conversion result, unsigned
//  sweep_done  out  1   1-clk strobe, coincident with the res_valid of the last channel in the sweep
//  busy        out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async, immediate, also mid-frame): cs_n=1, sck=1, din=0, res_valid=0, res_chan=0,
//   res_data=0, sweep_done=0, busy=0, state=IDLE, pend_valid=0, cur_chan=7.
//  FSM IDLE -> SETUP when scan_en && chan_mask!=0.
//   SETUP: CLK_DIV/2 clks. cs_n=0, sck=1. On entry, mask_q<=chan_mask and
//   addr<=next set bit of mask_q strictly above cur_chan, wrapping 7->0.
//   SHIFT: 16 SCLK cycles k=0..15. Each cycle: sck=0 for CLK_DIV/2 clks, then sck=1 for CLK_DIV/2.
//   -> GAP: GAP_CYC clks. cs_n=1, sck=1.
//   -> SETUP if scan_en && chan_mask!=0 at the last GAP clk; else IDLE.
//  DIN changes only on the sck falling edge. k=2,3,4 carry addr[2],addr[1],addr[0]; else 0.
//  DOUT is sampled on the sck rising edge for k=4..15, MSB first, into a 12-bit shift register.
//  The data in frame N belongs to the address sent in frame N-1 (pend_chan, pend_valid).
//  Result: in the first GAP clk, if pend_valid, then res_valid=1, res_chan=pend_chan,
//   res_data=shift register. After that, pend_chan<=addr, pend_valid<=1, cur_chan<=addr.
//   res_chan/res_data hold until the next strobe.
//  sweep_done=1 with res_valid when res_chan is the highest set bit of mask_q.
//  The first frame after IDLE or reset yields no strobe; its data is discarded.
//  Entering IDLE clears pend_valid.
//  Frame length = CLK_DIV/2 + 16*CLK_DIV + GAP_CYC clks; with the defaults this is 332 clks.
//  Strobe latency = one frame after the channel is addressed.
//  scan_en drop or mask->0 mid-frame: the frame completes, its pending result is still
//   strobed, then IDLE. No partial frames: cs_n never rises while the FSM is in SHIFT.
//  Mask change mid-sweep: takes effect at the next SETUP. The pending result is still reported
//   under the channel actually addressed, even if that channel is now disabled.
//  Single enabled channel: the same channel is addressed every frame, and sweep_done pulses with
//   every strobe.
//  Divider counter and bit counter are both free of wrap: they reset on every state entry.
// TESTING
//  1 Reset 3 clks, scan_en=0 -> cs_n=1, sck=1, din=0, busy=0, no strobes for 1000 clks.
//  2 mask=8'hE0, scan_en=1, ADC model returns 12'h100+ch ->
//    din address sequence 5,6,7,5...; strobes in order (5,12'h105), (6,12'h106), (7,12'h107);
//    sweep_done only with ch7; no strobe in frame 1; strobe period 332 clks.
//  3 Check SCLK timing: 16 falling edges per CS_N-low window, 10 clks low / 10 high,
//    and cs_n high for exactly 2 clks between frames.
//  4 Drop scan_en at clk 100 of frame 3 -> frame 3 completes, its strobe appears, then busy=0;
//    re-enable -> first frame gives no strobe.
//  5 mask=8'h80 -> every frame addresses 7; each strobe carries sweep_done=1.
//    mask->8'h00 mid-frame -> frame completes, then IDLE.
//  6 Assert rst_n=0 at bit k=7 -> cs_n=1 and sck=1 in the same clk, no strobe;
//    after release and scan_en=1 -> restart from the next channel above 7 (wrap to lowest).

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: round-robin frame master for an 8-channel 12-bit serial ADC (16-SCLK frames, data lags address by one frame)
module adc_scan_sequencer #(
  parameter int CLK_DIV = 20,
  parameter int GAP_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic [7:0]  chan_mask,
  input  logic        adc_dout,
  output logic        adc_sck,
  output logic        adc_cs_n,
  output logic        adc_din,
  output logic        res_valid,
  output logic [2:0]  res_chan,
  output logic [11:0] res_data,
  output logic        sweep_done,
  output logic        busy
);
  localparam int DW = $clog2((CLK_DIV > GAP_CYC ? CLK_DIV : GAP_CYC) + 1);
  localparam logic [DW-1:0] HALF_END = DW'(CLK_DIV / 2 - 1);
  localparam logic [DW-1:0] FULL_END = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_END = DW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [3:0]    bit_k;
  logic [7:0]    mask_q;
  logic [2:0]    addr;
  logic [2:0]    cur_chan;
  logic [2:0]    pend_chan;
  logic          pend_valid;
  logic [11:0]   sh;
  logic          start;
  logic [3:0]    nk;
  logic          nk_din;

  function automatic logic [2:0] next_chan(input logic [7:0] m, input logic [2:0] c);
    next_chan = c;
    for (int i = 8; i >= 1; i--) if (m[c + 3'(i)]) next_chan = c + 3'(i);
  endfunction

  function automatic logic [2:0] top_chan(input logic [7:0] m);
    top_chan = 3'd0;
    for (int i = 0; i < 8; i++) if (m[i]) top_chan = 3'(i);
  endfunction

  assign start = scan_en && (chan_mask != 8'd0);
  assign nk = bit_k + 4'd1;
  assign nk_din = nk == 4'd2 ? addr[2] : nk == 4'd3 ? addr[1] : nk == 4'd4 ? addr[0] : 1'b0;
  assign busy = state != IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      adc_cs_n <= 1'b1;
      adc_sck <= 1'b1;
      adc_din <= 1'b0;
      res_valid <= 1'b0;
      res_chan <= 3'd0;
      res_data <= 12'd0;
      sweep_done <= 1'b0;
      pend_valid <= 1'b0;
      pend_chan <= 3'd0;
      cur_chan <= 3'd7;
      addr <= 3'd0;
      mask_q <= 8'd0;
      sh <= 12'd0;
      div <= '0;
      bit_k <= 4'd0;
    end else begin
      res_valid <= 1'b0;
      sweep_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= SETUP;
          adc_cs_n <= 1'b0;
          mask_q <= chan_mask;
          addr <= next_chan(chan_mask, cur_chan);
          div <= '0;
        end
        SETUP: if (div == HALF_END) begin
          state <= SHIFT;
          adc_sck <= 1'b0;
          adc_din <= 1'b0;
          div <= '0;
          bit_k <= 4'd0;
        end else div <= div + 1'b1;
        SHIFT: begin
          div <= div + 1'b1;
          if (div == HALF_END) begin
            adc_sck <= 1'b1;
            if (bit_k >= 4'd4) sh <= {sh[10:0], adc_dout};
          end
          if (div == FULL_END) begin
            div <= '0;
            if (bit_k == 4'd15) begin
              state <= GAP;
              adc_cs_n <= 1'b1;
              adc_din <= 1'b0;
              res_valid <= pend_valid;
              sweep_done <= pend_valid && (pend_chan == top_chan(mask_q));
              if (pend_valid) begin
                res_chan <= pend_chan;
                res_data <= sh;
              end
              // this frame's address is answered by the next frame's data
              pend_chan <= addr;
              pend_valid <= 1'b1;
              cur_chan <= addr;
            end else begin
              bit_k <= nk;
              adc_sck <= 1'b0;
              adc_din <= nk_din;
            end
          end
        end
        GAP: if (div == GAP_END) begin
          div <= '0;
          if (start) begin
            state <= SETUP;
            adc_cs_n <= 1'b0;
            mask_q <= chan_mask;
            addr <= next_chan(chan_mask, cur_chan);
          end else begin
            state <= IDLE;
            pend_valid <= 1'b0;
          end
        end else div <= div + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: directed runs against a behavioural ADC, results checked by a strobe scoreboard
module tb_adc_scan_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic [7:0]  chan_mask = 8'd0;
  logic        adc_dout = 1'b0;
  logic        adc_sck, adc_cs_n, adc_din, res_valid, sweep_done, busy;
  logic [2:0]  res_chan;
  logic [11:0] res_data;

  adc_scan_sequencer dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .chan_mask(chan_mask), .adc_dout(adc_dout),
    .adc_sck(adc_sck), .adc_cs_n(adc_cs_n), .adc_din(adc_din), .res_valid(res_valid),
    .res_chan(res_chan), .res_data(res_data), .sweep_done(sweep_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  typedef struct {logic [2:0] ch; logic [11:0] data; logic sd; logic per;} exp_t;
  exp_t exp_q[$];
  logic [2:0] addr_q[$];

  task automatic push(input logic [2:0] ch, input logic sd, input logic per);
    exp_t e;
    e.ch = ch;
    e.data = 12'h100 + 12'(ch);
    e.sd = sd;
    e.per = per;
    exp_q.push_back(e);
  endtask

  // scoreboard monitor
  exp_t got;
  int last_strobe = 0;
  always @(negedge clk) if (rst_n && res_valid) begin
    check("strobe_pending", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      got = exp_q.pop_front();
      check("res_chan", res_chan, got.ch);
      check("res_data", res_data, got.data);
      check("sweep_done", sweep_done, got.sd);
      if (got.per) check("strobe_period", cyc - last_strobe, 332);
    end
    last_strobe = cyc;
  end

  // ADC model: address latched in one frame selects the data shifted out in the next
  int k = -1;
  logic [11:0] val = 12'd0;
  logic [2:0] sh = 3'd0;
  logic [2:0] last_addr = 3'd0;
  always @(negedge adc_cs_n or negedge adc_sck) if (!adc_cs_n) begin
    if (adc_sck) begin
      k = -1;
      val = 12'h100 + 12'(last_addr);
      adc_dout = 1'b0;
    end else begin
      k++;
      adc_dout = (k >= 4 && k <= 15) ? val[15 - k] : 1'b0;
    end
  end
  always @(posedge adc_sck or posedge adc_cs_n) begin
    if (adc_cs_n) begin
      if (k == 15) begin
        last_addr = sh;
        check("addr_pending", 32'(addr_q.size() != 0), 1);
        if (addr_q.size() != 0) check("din_addr", sh, addr_q.pop_front());
        k = -1;
      end
    end else if (k >= 2 && k <= 4) sh = {sh[1:0], adc_din};
  end

  // SCLK / CS_N timing monitor
  int frame_starts = 0;
  int falls = 0;
  int run = 0;
  int gap = 0;
  logic prev_low = 1'b0;
  logic prev_sck = 1'b1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (!adc_cs_n) begin
        if (!prev_low) begin
          run = 1;
          falls = 0;
          frame_starts++;
          if (gap > 0) check("cs_gap", gap, 2);
          gap = 0;
        end else if (adc_sck == prev_sck) run++;
        else begin
          check("sck_half", run, 10);
          if (!adc_sck) falls++;
          run = 1;
        end
      end else begin
        if (prev_low) begin
          check("sck_half_last", run, 10);
          check("sck_falls", falls, 16);
        end
        gap = busy ? gap + 1 : 0;
      end
      prev_low = !adc_cs_n;
      prev_sck = adc_sck;
    end else begin
      prev_low = 1'b0;
      gap = 0;
    end
  end

  task automatic wait_starts(input int n);
    for (int i = 0; i < 3000 && frame_starts < n; i++) @(posedge clk);
    if (frame_starts < n) check("timeout_frame", frame_starts, n);
  endtask

  task automatic wait_falls(input int n);
    for (int i = 0; i < 1000 && falls < n; i++) @(posedge clk);
    if (falls < n) check("timeout_falls", falls, n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy; i++) @(posedge clk);
    #1 check("busy_idle", busy, 0);
  endtask

  int base;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", adc_cs_n, 1);
    check("rst_sck", adc_sck, 1);
    check("rst_din", adc_din, 0);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_chan", res_chan, 0);
    check("rst_res_data", res_data, 0);
    check("rst_sweep_done", sweep_done, 0);
    rst_n = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_cs_n", adc_cs_n, 1);
    check("idle_sck", adc_sck, 1);
    // run A: mask E0, five frames, scan_en dropped inside frame 5
    push(3'd5, 1'b0, 1'b0); push(3'd6, 1'b0, 1'b1); push(3'd7, 1'b1, 1'b1); push(3'd5, 1'b0, 1'b1);
    addr_q = '{3'd5, 3'd6, 3'd7, 3'd5, 3'd6};
    base = frame_starts;
    chan_mask = 8'hE0;
    scan_en = 1'b1;
    wait_starts(base + 5);
    repeat (100) @(posedge clk);
    scan_en = 1'b0;
    wait_idle();
    check("hold_res_chan", res_chan, 5);
    check("hold_res_data", res_data, 12'h105);
    check("run_a_drained", exp_q.size(), 0);
    repeat (50) @(posedge clk);
    // run B: resume after channel 6, drop scan_en in frame 3
    push(3'd7, 1'b1, 1'b0); push(3'd5, 1'b0, 1'b1);
    addr_q = '{3'd7, 3'd5, 3'd6};
    base = frame_starts;
    scan_en = 1'b1;
    wait_starts(base + 3);
    repeat (100) @(posedge clk);
    scan_en = 1'b0;
    wait_idle();
    check("run_b_drained", exp_q.size(), 0);
    repeat (50) @(posedge clk);
    // run C: single channel 7, mask cleared in frame 3
    push(3'd7, 1'b1, 1'b0); push(3'd7, 1'b1, 1'b1);
    addr_q = '{3'd7, 3'd7, 3'd7};
    base = frame_starts;
    chan_mask = 8'h80;
    scan_en = 1'b1;
    wait_starts(base + 3);
    repeat (100) @(posedge clk);
    chan_mask = 8'h00;
    wait_idle();
    scan_en = 1'b0;
    check("run_c_drained", exp_q.size(), 0);
    repeat (50) @(posedge clk);
    // run D: mask 25, reset at bit 7 of frame 3, restart from the lowest channel
    push(3'd0, 1'b0, 1'b0);
    addr_q = '{3'd0, 3'd2};
    base = frame_starts;
    chan_mask = 8'h25;
    scan_en = 1'b1;
    wait_starts(base + 3);
    wait_falls(8);
    #2 rst_n = 1'b0;
    scan_en = 1'b0;
    #1;
    check("midrst_cs_n", adc_cs_n, 1);
    check("midrst_sck", adc_sck, 1);
    check("midrst_din", adc_din, 0);
    check("midrst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_res_chan", res_chan, 0);
    check("midrst_res_data", res_data, 0);
    rst_n = 1'b1;
    @(posedge clk);
    push(3'd0, 1'b0, 1'b0);
    addr_q.push_back(3'd0);
    addr_q.push_back(3'd2);
    base = frame_starts;
    scan_en = 1'b1;
    wait_starts(base + 2);
    repeat (100) @(posedge clk);
    scan_en = 1'b0;
    wait_idle();
    repeat (50) @(posedge clk);
    check("final_strobes_drained", exp_q.size(), 0);
    check("final_addr_drained", addr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
